// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter with its own baud divider and configurable frame format.
module uart_tx_fifo #(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DATA_BITS-1:0]        tx_data,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    output logic                        rs232_tx,
    output logic                        tx_busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
    localparam int DIV = CLK_HZ / BAUD;
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW:0]   FULL      = (PW + 1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

    if (DATA_BITS < 5 || DATA_BITS > 9 || (STOP_BITS != 1 && STOP_BITS != 2) || PARITY < 0 ||
        PARITY > 2 || DIV < 2 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_cfg_err
        $error("uart_tx_fifo: illegal parameter combination");
    end

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY_BIT, STOP} state_t;

    state_t               state, state_nxt;
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr, rd_ptr;
    logic [CW-1:0]        cnt, cnt_nxt;
    logic [3:0]           bit_cnt, bit_nxt;
    logic [DATA_BITS-1:0] shreg, shreg_nxt, word, word_nxt;
    logic                 push, pop, tick, par, line_nxt;

    assign tx_ready = fifo_level != FULL;
    assign push     = tx_valid & tx_ready;
    assign tick     = cnt == CNT_LAST;
    assign par      = (PARITY == 2) ? ^word : ~^word;
    assign tx_busy  = (state != IDLE) | (fifo_level != '0);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= tx_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            wr_ptr     <= wr_ptr + PW'(push);
            rd_ptr     <= rd_ptr + PW'(pop);
            fifo_level <= fifo_level + (PW + 1)'(push) - (PW + 1)'(pop);
        end
    end

    // The line is registered from the current state, so each bit appears one clock after its state begins.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = (state == IDLE || tick) ? '0 : cnt + 1'b1;
        bit_nxt   = bit_cnt;
        shreg_nxt = shreg;
        word_nxt  = word;
        pop       = 1'b0;
        line_nxt  = state == START ? 1'b0 : state == DATA ? shreg[0] : state == PARITY_BIT ? par : 1'b1;
        case (state)
            IDLE:       pop = fifo_level != '0;
            START:      if (tick) begin
                            state_nxt = DATA;
                            bit_nxt   = '0;
                        end
            DATA:       if (tick) begin
                            shreg_nxt = shreg >> 1;
                            bit_nxt   = bit_cnt + 1'b1;
                            if (bit_cnt == DATA_LAST) begin
                                state_nxt = (PARITY != 0) ? PARITY_BIT : STOP;
                                bit_nxt   = '0;
                            end
                        end
            PARITY_BIT: if (tick) begin
                            state_nxt = STOP;
                            bit_nxt   = '0;
                        end
            STOP:       if (tick) begin
                            bit_nxt = bit_cnt + 1'b1;
                            if (bit_cnt == STOP_LAST) begin
                                state_nxt = IDLE;
                                pop       = fifo_level != '0;
                            end
                        end
            default:    state_nxt = IDLE;
        endcase
        // Popping always starts a new frame, whether from IDLE or straight out of the last stop bit.
        if (pop) begin
            state_nxt = START;
            shreg_nxt = mem[rd_ptr];
            word_nxt  = mem[rd_ptr];
            bit_nxt   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            word     <= '0;
            rs232_tx <= 1'b1;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            bit_cnt  <= bit_nxt;
            shreg    <= shreg_nxt;
            word     <= word_nxt;
            rs232_tx <= line_nxt;
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: four frame formats at DIV=10 checked against a frame-timing reference model plus directed vectors.
module tb_uart_tx_fifo;
    localparam int DIV   = 10;
    localparam int NI    = 4;
    localparam int DEPTH = 4;
    localparam int MAXF  = 512;
    localparam int DB [NI] = '{8, 8, 8, 7};
    localparam int PA [NI] = '{0, 2, 1, 0};
    localparam int SB [NI] = '{1, 2, 2, 1};

    typedef struct {
        int         inst;
        logic [8:0] data;
        logic [12:0] bits;
        int         nb;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic [NI-1:0][8:0] din;
    logic [NI-1:0]      vld, rdy, line, busy;
    logic [NI-1:0][2:0] lvl;
    int n_cmp = 0;
    int n_bad = 0;
    int e = 0;
    int nf [NI];
    int last_end [NI];
    int fp [NI][MAXF];
    int fs [NI][MAXF];
    logic [8:0] fw [NI][MAXF];

    always #5 clk = ~clk;

    uart_tx_fifo #(.CLK_HZ(1000000), .BAUD(100000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
        .clk(clk), .rst(rst), .tx_data(din[0][7:0]), .tx_valid(vld[0]), .tx_ready(rdy[0]),
        .rs232_tx(line[0]), .tx_busy(busy[0]), .fifo_level(lvl[0]));
    uart_tx_fifo #(.CLK_HZ(1000000), .BAUD(100000), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) u1 (
        .clk(clk), .rst(rst), .tx_data(din[1][7:0]), .tx_valid(vld[1]), .tx_ready(rdy[1]),
        .rs232_tx(line[1]), .tx_busy(busy[1]), .fifo_level(lvl[1]));
    uart_tx_fifo #(.CLK_HZ(1000000), .BAUD(100000), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) u2 (
        .clk(clk), .rst(rst), .tx_data(din[2][7:0]), .tx_valid(vld[2]), .tx_ready(rdy[2]),
        .rs232_tx(line[2]), .tx_busy(busy[2]), .fifo_level(lvl[2]));
    uart_tx_fifo #(.CLK_HZ(1000000), .BAUD(100000), .DATA_BITS(7), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u3 (
        .clk(clk), .rst(rst), .tx_data(din[3][6:0]), .tx_valid(vld[3]), .tx_ready(rdy[3]),
        .rs232_tx(line[3]), .tx_busy(busy[3]), .fifo_level(lvl[3]));

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int flen(int i);
        return (1 + DB[i] + ((PA[i] != 0) ? 1 : 0) + SB[i]) * DIV;
    endfunction

    function automatic logic fbit(int i, logic [8:0] w, int k);
        if (k == 0) return 1'b0;
        if (k <= DB[i]) return w[k-1];
        if (PA[i] != 0 && k == DB[i] + 1) return (PA[i] == 2) ? ^w : ~^w;
        return 1'b1;
    endfunction

    // Words pushed by edge t minus words whose frame started popping (one edge before line start) by edge t.
    function automatic int level_at(int i, int t);
        int lv = 0;
        for (int k = 0; k < nf[i]; k++) begin
            if (fp[i][k] <= t) lv++;
            if (fs[i][k] - 1 <= t) lv--;
        end
        return lv;
    endfunction

    task automatic model_out(input int i, input int t, output logic l, output logic b, output logic [2:0] lv);
        int L = flen(i);
        lv = 3'(level_at(i, t));
        b  = lv != 3'd0;
        l  = 1'b1;
        for (int k = 0; k < nf[i]; k++) begin
            if (fs[i][k] - 1 <= t && t < fs[i][k] + L - 1) b = 1'b1;
            if (fs[i][k] <= t && t < fs[i][k] + L) l = fbit(i, fw[i][k], (t - fs[i][k]) / DIV);
        end
    endtask

    // Frame of a word accepted at edge N starts at N+2, or right after the previous frame if that is later.
    initial forever begin
        int s;
        @(posedge clk or posedge rst);
        if (rst) begin
            e = 0;
            for (int i = 0; i < NI; i++) begin
                nf[i] = 0;
                last_end[i] = 0;
            end
        end else begin
            e++;
            for (int i = 0; i < NI; i++) begin
                if (vld[i] && level_at(i, e - 1) != DEPTH) begin
                    s = (e + 2 > last_end[i]) ? e + 2 : last_end[i];
                    if (nf[i] < MAXF) begin
                        fp[i][nf[i]] = e;
                        fs[i][nf[i]] = s;
                        fw[i][nf[i]] = din[i] & 9'((1 << DB[i]) - 1);
                        nf[i]++;
                    end
                    last_end[i] = s + flen(i);
                end
            end
        end
    end

    initial forever begin
        logic l, b;
        logic [2:0] lv;
        @(negedge clk);
        if (!rst) begin
            for (int i = 0; i < NI; i++) begin
                model_out(i, e, l, b, lv);
                chk($sformatf("mon line u%0d @%0d", i, e), line[i], l);
                chk($sformatf("mon busy u%0d @%0d", i, e), busy[i], b);
                chk($sformatf("mon level u%0d @%0d", i, e), lvl[i], lv);
                chk($sformatf("mon ready u%0d @%0d", i, e), rdy[i], lv != 3'd4);
            end
        end
    end

    task automatic chk_idle(input string tag);
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("%s line u%0d", tag, i), line[i], 1);
            chk($sformatf("%s ready u%0d", tag, i), rdy[i], 1);
            chk($sformatf("%s busy u%0d", tag, i), busy[i], 0);
            chk($sformatf("%s level u%0d", tag, i), lvl[i], 0);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int L = v.nb * DIV;
        chk($sformatf("vec u%0d ready", v.inst), rdy[v.inst], 1);
        din[v.inst] = v.data;
        vld[v.inst] = 1'b1;
        @(posedge clk);
        #1 vld[v.inst] = 1'b0;
        for (int t = 0; t <= L + 2; t++) begin
            @(negedge clk);
            chk($sformatf("vec u%0d %0h line t=%0d", v.inst, v.data, t), line[v.inst],
                (t >= 2 && t < L + 2) ? v.bits[(t - 2) / DIV] : 1'b1);
            chk($sformatf("vec u%0d %0h busy t=%0d", v.inst, v.data, t), busy[v.inst], t <= L);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic decode(input int n, input logic [7:0] ew [8]);
        int t = 0;
        int g = 0;
        logic [9:0] fr;
        while (line[0] !== 1'b0 && g < 1000) begin
            @(negedge clk);
            g++;
        end
        chk("decode start seen", g < 1000, 1);
        for (int j = 0; j < n; j++) begin
            for (int k = 0; k < 10; k++) begin
                while (t < j * 100 + k * DIV + DIV / 2) begin
                    @(negedge clk);
                    t++;
                end
                fr[k] = line[0];
            end
            chk($sformatf("decode frame %0d", j), fr, {1'b1, ew[j], 1'b0});
        end
    endtask

    task automatic drain(input string tag);
        int g = 0;
        vld = '0;
        while (busy != '0 && g < 3000) begin
            @(posedge clk);
            #1 g++;
        end
        chk(tag, busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt [6];
        int dens [4];
        int g;
        logic saw_full;
        rst = 1'b1;
        vld = '0;
        din = '0;
        saw_full = 1'b0;
        dens = '{5, 60, 100, 2};
        vt[0] = '{0, 9'h0A5, 13'({1'b1, 8'hA5, 1'b0}), 10};
        vt[1] = '{1, 9'h007, 13'({2'b11, 1'b1, 8'h07, 1'b0}), 12};
        vt[2] = '{2, 9'h007, 13'({2'b11, 1'b0, 8'h07, 1'b0}), 12};
        vt[3] = '{3, 9'h055, 13'({1'b1, 7'h55, 1'b0}), 9};
        vt[4] = '{1, 9'h0FF, 13'({2'b11, 1'b0, 8'hFF, 1'b0}), 12};
        vt[5] = '{2, 9'h000, 13'({2'b11, 1'b1, 8'h00, 1'b0}), 12};
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk_idle("post-reset");
        repeat (5) @(posedge clk);
        #1 chk_idle("idle");

        for (int j = 0; j < 6; j++) run_vec(vt[j]);

        fork
            begin
                vld[0] = 1'b1;
                for (int w = 1; w <= 6; w++) begin
                    din[0] = 9'(w);
                    g = 0;
                    while (!rdy[0] && g < 2000) begin
                        if (lvl[0] == 3'd4) saw_full = 1'b1;
                        @(posedge clk);
                        #1 g++;
                    end
                    @(posedge clk);
                    #1;
                    if (lvl[0] == 3'd4 && !rdy[0]) saw_full = 1'b1;
                end
                vld[0] = 1'b0;
            end
            decode(6, '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h00, 8'h00});
        join
        chk("fifo full with ready low", saw_full, 1);
        drain("drain after back-to-back");

        fork
            begin
                for (int w = 0; w < 3; w++) begin
                    din[0] = 9'(8'h11 * (w + 1));
                    vld[0] = 1'b1;
                    @(posedge clk);
                    #1;
                end
                vld[0] = 1'b0;
                chk("push/pop level after three pushes", lvl[0], 2);
                repeat (98) @(posedge clk);
                #1 chk("push/pop level before pop edge", lvl[0], 2);
                din[0] = 9'h044;
                vld[0] = 1'b1;
                @(posedge clk);
                #1 vld[0] = 1'b0;
                chk("push/pop level at pop edge", lvl[0], 2);
            end
            decode(4, '{8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00, 8'h00, 8'h00});
        join
        drain("drain after push/pop");

        din = '0;
        vld = '1;
        repeat (2) @(posedge clk);
        #1 vld = '0;
        repeat (35) @(posedge clk);
        #1 chk("busy before async reset", busy, 4'hF);
        #2 rst = 1'b1;
        #1 chk_idle("async reset");
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk_idle("after release");
        repeat (20) @(posedge clk);
        #1 chk_idle("quiet after reset");

        for (int b = 0; b < 4; b++) begin
            for (int c = 0; c < 1000; c++) begin
                for (int i = 0; i < NI; i++) begin
                    vld[i] = $urandom_range(0, 99) < dens[b];
                    din[i] = 9'($urandom);
                end
                @(posedge clk);
                #1;
            end
        end
        drain("drain after random");
        chk_idle("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
